// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: latches a source page from a CPU register write,
// waits a startup delay, then copies LENGTH bytes from {page, idx} on the
// system bus into OAM addresses 0..LENGTH-1, one byte per slot.
module oam_dma_ctrl #(
  parameter int LENGTH          = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int STARTUP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write,
  input  logic [7:0]  reg_d_wr,
  output logic [7:0]  reg_d_rd,
  output logic [15:0] dma_src_addr,
  input  logic [7:0]  dma_d_in,
  output logic        dma_active,
  output logic        busy,
  input  logic        oam_grant,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_d_wr,
  output logic        oam_write,
  output logic        done
);

  localparam int SUB_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int CTR_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_BYTE - 1);
  localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(STARTUP_CYCLES - 1);
  localparam logic [7:0]       IDX_LAST = 8'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } state_t;

  state_t           state, state_n;
  logic [7:0]       page, page_n;
  logic [7:0]       idx, idx_n;
  logic [SUB_W-1:0] sub, sub_n;
  logic [CTR_W-1:0] start_ctr, start_ctr_n;
  logic             done_n;

  logic [7:0]       eff_page;
  logic             write_slot;
  logic             byte_write;

  // Pages E0..FF are the echo of C0..DF, so fetch from the mirrored page.
  assign eff_page   = (page > 8'hDF) ? (page - 8'h20) : page;

  // Last clock of a slot is the write opportunity; a CPU restart in the same
  // clock discards the in-flight byte.
  assign write_slot = (state == XFER) && (sub == SUB_LAST);
  assign byte_write = write_slot && oam_grant && !reg_write;

  assign reg_d_rd     = page;
  assign dma_active   = (state == XFER);
  assign busy         = (state != IDLE);
  assign dma_src_addr = dma_active ? {eff_page, idx} : 16'h0000;
  assign oam_write    = byte_write;
  assign oam_addr     = byte_write ? idx : 8'h00;
  assign oam_d_wr     = byte_write ? dma_d_in : 8'h00;

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      sub       <= '0;
      start_ctr <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      page      <= page_n;
      idx       <= idx_n;
      sub       <= sub_n;
      start_ctr <= start_ctr_n;
      done      <= done_n;
    end
  end

  // Next-state logic: register writes always restart, otherwise step the FSM.
  always_comb begin
    state_n     = state;
    page_n      = page;
    idx_n       = idx;
    sub_n       = sub;
    start_ctr_n = start_ctr;
    done_n      = 1'b0;

    if (reg_write) begin
      page_n      = reg_d_wr;
      start_ctr_n = CTR_LOAD;
      idx_n       = 8'h00;
      sub_n       = '0;
      state_n     = START;
    end else begin
      case (state)
        IDLE: begin
          state_n = IDLE;
        end
        START: begin
          if (start_ctr == '0) begin
            state_n = XFER;
            idx_n   = 8'h00;
            sub_n   = '0;
          end else begin
            start_ctr_n = start_ctr - 1'b1;
          end
        end
        XFER: begin
          if (write_slot) begin
            if (oam_grant) begin
              sub_n = '0;
              if (idx == IDX_LAST) begin
                state_n = IDLE;
                idx_n   = 8'h00;
                done_n  = 1'b1;
              end else begin
                idx_n = idx + 1'b1;
              end
            end
          end else begin
            sub_n = sub + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a timing/data reference model
// predicts every OAM write and done pulse from the transfer rules, and the
// observed strobes are compared against it after each scenario.
module tb_oam_dma_ctrl;

  localparam int LENGTH = 160;
  localparam int CPB    = 4;
  localparam int SU     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [7:0]  reg_d_wr;
  logic [7:0]  reg_d_rd;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_d_in;
  logic        dma_active;
  logic        busy;
  logic        oam_grant;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d_wr;
  logic        oam_write;
  logic        done;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int viol         = 0;
  int stall_ws     = -1;
  int stall_len    = 0;
  logic [7:0] bus_mask = 8'h00;

  logic [63:0] exp_w[$];
  logic [63:0] act_w[$];
  int          exp_d[$];
  int          act_d[$];

  oam_dma_ctrl #(
    .LENGTH(LENGTH),
    .CYCLES_PER_BYTE(CPB),
    .STARTUP_CYCLES(SU)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reg_write(reg_write),
    .reg_d_wr(reg_d_wr),
    .reg_d_rd(reg_d_rd),
    .dma_src_addr(dma_src_addr),
    .dma_d_in(dma_d_in),
    .dma_active(dma_active),
    .busy(busy),
    .oam_grant(oam_grant),
    .oam_addr(oam_addr),
    .oam_d_wr(oam_d_wr),
    .oam_write(oam_write),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bus_fn(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] & bus_mask);
  endfunction

  // System bus model: read data appears one clock after the address.
  always @(posedge clk) dma_d_in <= bus_fn(dma_src_addr);

  function automatic logic [7:0] mirror(input int p);
    return (p >= 224) ? 8'(p - 32) : 8'(p);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: write k of a transfer whose strobe was in cycle s lands
  // in cycle s+1+SU+(CPB-1)+CPB*k, pushed back by any stall before it.
  task automatic expect_xfer(input int s, input int p, input int count,
                             input int sidx, input int slen, input bit with_done);
    int e;
    int t;
    logic [15:0] src;
    e = s + 1;
    for (int k = 0; k < count; k++) begin
      t   = e + SU + (CPB - 1) + CPB * k + ((k >= sidx) ? slen : 0);
      src = {mirror(p), 8'(k)};
      exp_w.push_back({32'(t), src, 8'(k), bus_fn(src)});
    end
    if (with_done)
      exp_d.push_back(e + SU + LENGTH * CPB + ((sidx < LENGTH) ? slen : 0));
  endtask

  task automatic apply_stimulus(input logic wr, input logic [7:0] d);
    @(posedge clk);
    cyc++;
    #1;
    reg_write = wr;
    reg_d_wr  = d;
    oam_grant = !(stall_ws >= 0 && cyc >= stall_ws && cyc < stall_ws + stall_len);
    #1;
    if (oam_write === 1'b1) act_w.push_back({32'(cyc), dma_src_addr, oam_addr, oam_d_wr});
    if (done === 1'b1) act_d.push_back(cyc);
    if (oam_write !== 1'b1 && (oam_addr !== 8'h00 || oam_d_wr !== 8'h00)) viol++;
    if (oam_write === 1'b1 && dma_active !== 1'b1) viol++;
    if (done === 1'b1 && busy !== 1'b0) viol++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) apply_stimulus(1'b0, 8'($urandom));
  endtask

  task automatic check_output(input string tag);
    int n;
    check({tag, " write count"}, 64'(act_w.size()), 64'(exp_w.size()));
    n = (act_w.size() < exp_w.size()) ? act_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) check({tag, " write"}, act_w[i], exp_w[i]);
    check({tag, " done count"}, 64'(act_d.size()), 64'(exp_d.size()));
    n = (act_d.size() < exp_d.size()) ? act_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) check({tag, " done cycle"}, 64'(act_d[i]), 64'(exp_d[i]));
    check({tag, " strobe rules"}, 64'(viol), 64'(0));
    viol = 0;
    act_w.delete();
    exp_w.delete();
    act_d.delete();
    exp_d.delete();
  endtask

  task automatic do_xfer(input string tag, input int p, input int sidx, input int slen);
    int s;
    apply_stimulus(1'b1, 8'(p));
    s         = cyc;
    stall_ws  = (sidx < LENGTH) ? (s + 1 + SU + (CPB - 1) + CPB * sidx) : -1;
    stall_len = slen;
    expect_xfer(s, p, LENGTH, sidx, slen, 1'b1);
    apply_stimulus(1'b0, 8'($urandom));
    check({tag, " reg_d_rd"}, 64'(reg_d_rd), 64'(p));
    check({tag, " start flags"}, 64'({busy, dma_active}), 64'(2'b10));
    run_to(s + 1 + 100);
    check({tag, " xfer flags"}, 64'({busy, dma_active}), 64'(2'b11));
    run_to(s + 1 + SU + LENGTH * CPB + slen + 3);
    check({tag, " idle flags"}, 64'({busy, dma_active}), 64'(2'b00));
    stall_ws = -1;
    check_output(tag);
  endtask

  task automatic do_restart(input string tag, input int p1, input int p2, input int at_idx);
    int s1;
    int s2;
    apply_stimulus(1'b1, 8'(p1));
    s1 = cyc;
    expect_xfer(s1, p1, at_idx, LENGTH, 0, 1'b0);
    run_to(s1 + 1 + SU + (CPB - 1) + CPB * at_idx - 1);
    apply_stimulus(1'b1, 8'(p2));
    s2 = cyc;
    expect_xfer(s2, p2, LENGTH, LENGTH, 0, 1'b1);
    run_to(s2 + 1 + SU + LENGTH * CPB + 3);
    check_output(tag);
  endtask

  // Directed and randomized scenarios run in sequence.
  initial begin
    int p;
    int s;
    logic [43:0] outs;
    rst       = 1'b1;
    reg_write = 1'b0;
    reg_d_wr  = 8'h00;
    oam_grant = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    outs = {reg_d_rd, dma_src_addr, dma_active, busy, oam_addr, oam_d_wr, oam_write, done};
    check("reset outputs", 64'(outs), 64'(0));
    #1 rst = 1'b0;

    bus_mask = 8'h00;
    do_xfer("basic", 8'hC1, LENGTH, 0);

    bus_mask = 8'($urandom);
    do_xfer("echo", 8'hFE, LENGTH, 0);

    bus_mask = 8'($urandom);
    do_xfer("stall", int'($urandom_range(0, 223)), 10, 5);

    do_restart("restart", 8'hC0, 8'hD0, 50);
    do_restart("restart final", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), LENGTH - 1);

    for (int r = 0; r < 3; r++) begin
      bus_mask = 8'($urandom);
      do_xfer("random", int'($urandom_range(0, 255)),
              int'($urandom_range(0, LENGTH - 1)), int'($urandom_range(0, 7)));
    end

    p = int'($urandom_range(0, 255));
    apply_stimulus(1'b1, 8'(p));
    s = cyc;
    expect_xfer(s, p, 25, LENGTH, 0, 1'b0);
    run_to(s + 1 + SU + (CPB - 1) + CPB * 25 - 1);
    @(posedge clk);
    cyc++;
    #1;
    reg_write = 1'b0;
    oam_grant = 1'b1;
    #1;
    check("pre-reset strobe", 64'(oam_write), 64'(1));
    rst = 1'b1;
    #1;
    outs = {reg_d_rd, dma_src_addr, dma_active, busy, oam_addr, oam_d_wr, oam_write, done};
    check("reset mid xfer", 64'(outs), 64'(0));
    apply_stimulus(1'b0, 8'h00);
    apply_stimulus(1'b0, 8'h00);
    rst = 1'b0;
    #1;
    check("reg_d_rd after reset", 64'(reg_d_rd), 64'(0));
    run_to(cyc + 10);
    check_output("reset abort");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
Sequences OAM DMA for the PPU. A CPU write to the DMA register latches a source page; after a startup delay the block copies LENGTH bytes from {page, idx} on the system bus into OAM byte addresses 0..LENGTH-1. While copying it owns the bus and drives the OAM write port. It sits between the CPU register decode, the system bus and the PPU's OAM write path.

Parameters:
LENGTH, 160, bytes per transfer (1..256)
CYCLES_PER_BYTE, 4, clocks per byte slot (>=2)
STARTUP_CYCLES, 4, clocks from register write to first slot (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
reg_write  in  1  CPU write strobe to DMA register
reg_d_wr  in  8  source page written by CPU
reg_d_rd  out  8  last written page, unmodified
dma_src_addr  out  16  bus read address, {eff_page, idx[7:0]}
dma_d_in  in  8  bus read data, valid one clock after address
dma_active  out  1  bus owned by DMA (XFER state)
busy  out  1  START or XFER
oam_grant  in  1  OAM write port available this clock
oam_addr  out  8  OAM byte address
oam_d_wr  out  8  OAM write data
oam_write  out  1  OAM byte write strobe
done  out  1  one-clock pulse after last byte written

Behaviour:
- Reset (async, immediate): state IDLE; reg_d_rd=0, page=0, idx=0, sub=0; dma_active=0, busy=0, oam_write=0, done=0, dma_src_addr=0, oam_addr=0, oam_d_wr=0.
- eff_page = page if page<=8'hDF, else page-8'h20 (echo mirror). reg_d_rd is always the raw page.
- States: IDLE, START, XFER.
- IDLE: reg_write -> latch page, start_ctr=STARTUP_CYCLES-1, go START.
- START: decrement start_ctr; at 0 go XFER with idx=0, sub=0. busy=1, dma_active=0.
- XFER: dma_active=1, busy=1. dma_src_addr={eff_page, idx} held for the whole slot. sub counts 0..CYCLES_PER_BYTE-1.
- Write cycle: sub==CYCLES_PER_BYTE-1 and oam_grant=1. That clock: oam_write=1, oam_addr=idx, oam_d_wr=dma_d_in (combinational pass-through). Then sub<=0, idx<=idx+1.
- Stall: sub==CYCLES_PER_BYTE-1 and oam_grant=0. Hold sub, idx and address; no write; retry each clock. A stall never drops or duplicates a byte.
- Completion: write with idx==LENGTH-1 -> next clock IDLE, done=1 for one clock, dma_active=0, idx=0.
- oam_write is asserted only in XFER at a granted write cycle. oam_addr and oam_d_wr are 0 when oam_write=0.
- Restart: reg_write in START or XFER relatches page and reloads start_ctr. Go START, idx=0, sub=0, no done. Any in-flight byte in that clock is not written, even if oam_grant=1.
- reg_write on the same clock as the final write: restart wins, no done pulse, new transfer begins.
- Busy time with no stalls = STARTUP_CYCLES + LENGTH*CYCLES_PER_BYTE clocks from the reg_write edge to the done-high clock.
- rst asserted mid-transfer aborts immediately. OAM contents already written are left untouched.
- idx is 8 bits. No wrap is possible since LENGTH<=256.

Test Plan:
- Reset values: assert rst mid-XFER -> all outputs 0 same clock, busy=0; reg_d_rd=0 after release.
- Basic copy: write 8'hC1, bus model returns low address byte XOR 8'h5A, oam_grant=1 -> 160 writes, oam_addr 0..159, data idx^8'h5A. done pulses exactly 644 clocks after the write. First write at clock 4+3=7 after the write edge.
- Echo page: write 8'hFE -> reg_d_rd=8'hFE, dma_src_addr=16'hDE00..16'hDE9F.
- Stall: drop oam_grant for 5 clocks at idx=10's write cycle -> no oam_write during the stall. Byte 10 written once on grant return; done delayed by exactly 5 clocks.
- Restart: write 8'hC0, then 8'hD0 when idx=50 -> no write in the restart clock. START repeats, writes resume at oam_addr 0 from 16'hD000, single done at end.
- Restart on final byte: reg_write coincides with the idx=159 write cycle -> oam_write=0 that clock, no done, new 160-byte transfer completes.
